dcache_ctrl: RTL
================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: INDEX_W, default 6, number of index bits (2**INDEX_W lines, one 32-bit word per line).
REQ-002 Parameter: ADDR_W, default 22, word-address width; tag width SHALL be ADDR_W-INDEX_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  MEM-stage request present.
REQ-006 cmd  input  1  0 = read, 1 = write.
REQ-007 addr  input  ADDR_W  word address; index = addr[INDEX_W-1:0], tag = upper bits.
REQ-008 data  input  32  write data.
REQ-009 result  output  32  read data to MEM stage.
REQ-010 cache_hit  output  1  read hit this cycle.
REQ-011 stall  output  1  request not complete; requester holds req_valid/cmd/addr/data stable.
REQ-012 bk_req  output  1  backing-memory request.
REQ-013 bk_we  output  1  backing write (1) / read (0).
REQ-014 bk_addr  output  ADDR_W  backing address.
REQ-015 bk_wdata  output  32  backing write data.
REQ-016 bk_rdata  input  32  backing read data, valid with bk_ack.
REQ-017 bk_ack  input  1  one-cycle completion pulse from backing memory.

Function
REQ-018 Direct-mapped, write-through, no write-allocate; per line: valid bit, tag, data word.
REQ-019 States: IDLE, RD_MISS, WR_THRU, RESP.
REQ-020 IDLE, req_valid, cmd=0, valid and tag match: cache_hit=1, result=line data, stall=0, same cycle (combinational); state stays IDLE.
REQ-021 IDLE, read miss: stall=1 same cycle; latch addr; next state RD_MISS.
REQ-022 IDLE, req_valid, cmd=1: stall=1 same cycle; latch addr/data; on tag hit update line data at this edge; next state WR_THRU.
REQ-023 RD_MISS/WR_THRU: bk_req=1, bk_addr=latched addr, bk_we=0/1 respectively, bk_wdata=latched data; stall=1; hold until bk_ack.
REQ-024 On bk_ack in RD_MISS: write line (valid=1, latched tag, bk_rdata); register bk_rdata into result; next RESP.
REQ-025 On bk_ack in WR_THRU: next RESP; cache contents unchanged.
REQ-026 RESP: stall=0, cache_hit=0, result=registered fill data (read) or 0 (write); inputs ignored; next IDLE unconditionally.
REQ-027 bk_ack outside RD_MISS/WR_THRU SHALL be ignored; bk_ack in the first cycle bk_req is high SHALL be accepted.
REQ-028 IDLE without req_valid: stall=0, cache_hit=0, result=0, bk_req=0.
REQ-029 Read-miss latency: request cycle + RD_MISS cycles until bk_ack + one RESP cycle; hit latency 0.
REQ-030 Conflict miss replaces the resident line; index wrap is inherent (no alias handling).

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, clear all valid bits, and drive result, cache_hit, stall, bk_req, bk_we, bk_addr, bk_wdata to 0.
REQ-032 Reset mid-RD_MISS/WR_THRU SHALL abandon the transaction with no line written; data/tag arrays need not be reset.

Structure
REQ-033 Shared package dcache_pkg: state enum, CMD_READ/CMD_WRITE constants, default INDEX_W/ADDR_W.
REQ-034 One sub-module dcache_array: valid/tag/data storage, combinational read, single write port, async valid clear.

Verification
REQ-035 Reset, read addr 0x00005 with bk_rdata=0xDEADBEEF after 3 cycles -> cache_hit=0, stall high through RD_MISS, RESP result=0xDEADBEEF; repeat read -> cache_hit=1, result=0xDEADBEEF, stall=0.
REQ-036 Write 0x00005 data 0x12345678 after fill -> bk_req=1, bk_we=1, bk_wdata=0x12345678; after bk_ack read 0x00005 hits with 0x12345678.
REQ-037 Write miss 0x00009 -> write-through only; subsequent read 0x00009 misses (no allocate).
REQ-038 Fill 0x00005 then read 0x00045 (same index, different tag) -> miss and replacement; read 0x00005 then misses.
REQ-039 Assert rst_n low mid-RD_MISS -> bk_req and stall drop immediately; after release, read of same address misses.
REQ-040 bk_ack held high during IDLE/RESP -> no state change, no array write.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and defaults for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int DEF_INDEX_W = 6;
    localparam int DEF_ADDR_W  = 22;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_MISS,
        ST_WR_THRU,
        ST_RESP
    } state_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// one write port, valid bits cleared asynchronously by reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; a cleared valid bit makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete in the request cycle; misses and writes go to backing memory.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    output logic [31:0]       result,
    output logic              cache_hit,
    output logic              stall,
    output logic              bk_req,
    output logic              bk_we,
    output logic [ADDR_W-1:0] bk_addr,
    output logic [31:0]       bk_wdata,
    input  logic [31:0]       bk_rdata,
    input  logic              bk_ack
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_t             state_q;
    logic [31:0]        resp_data_q;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [31:0]        line_data;
    logic               tag_hit;
    logic               idle_req;
    logic               read_hit;
    logic               write_hit;
    logic               fill;
    logic               busy;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_index;
    logic [TAG_W-1:0]   wr_tag;
    logic [31:0]        wr_data;

    assign req_index = addr[INDEX_W-1:0];
    assign req_tag   = addr[ADDR_W-1:INDEX_W];
    assign tag_hit   = line_valid && (line_tag == req_tag);
    assign idle_req  = (state_q == ST_IDLE) && req_valid;
    assign read_hit  = idle_req && (cmd == CMD_READ) && tag_hit;
    assign write_hit = idle_req && (cmd == CMD_WRITE) && tag_hit;
    assign fill      = (state_q == ST_RD_MISS) && bk_ack;
    assign busy      = (state_q == ST_RD_MISS) || (state_q == ST_WR_THRU);

    // The single write port serves both a write hit (request address) and a fill (latched address).
    assign wr_en    = fill || write_hit;
    assign wr_index = fill ? bk_addr[INDEX_W-1:0]      : req_index;
    assign wr_tag   = fill ? bk_addr[ADDR_W-1:INDEX_W] : req_tag;
    assign wr_data  = fill ? bk_rdata                  : data;

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (req_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    // NOTE: stall is gated by rst_n so it reads 0 while reset is held, even with a request pending.
    assign stall     = rst_n && (busy || (idle_req && !read_hit));
    assign cache_hit = read_hit;

    always_comb begin
        result = '0;
        if (read_hit) begin
            result = line_data;
        end else if (state_q == ST_RESP) begin
            result = resp_data_q;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            resp_data_q <= '0;
            bk_req      <= 1'b0;
            bk_we       <= 1'b0;
            bk_addr     <= '0;
            bk_wdata    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && (cmd == CMD_WRITE)) begin
                        state_q  <= ST_WR_THRU;
                        bk_req   <= 1'b1;
                        bk_we    <= 1'b1;
                        bk_addr  <= addr;
                        bk_wdata <= data;
                    end else if (req_valid && !tag_hit) begin
                        state_q  <= ST_RD_MISS;
                        bk_req   <= 1'b1;
                        bk_we    <= 1'b0;
                        bk_addr  <= addr;
                        bk_wdata <= data;
                    end
                end
                ST_RD_MISS, ST_WR_THRU: begin
                    if (bk_ack) begin
                        state_q     <= ST_RESP;
                        resp_data_q <= (state_q == ST_RD_MISS) ? bk_rdata : 32'h0;
                        bk_req      <= 1'b0;
                        bk_we       <= 1'b0;
                        bk_addr     <= '0;
                        bk_wdata    <= '0;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
